// File: rtl/ascon_pack.sv
// Shared ASCON types and the p_C round-constant decode.
// Pure declarations; used by the constant adder, the round counter and the bench.
package ascon_pack;

    typedef logic [63:0] type_word;

    // Word 0 is the most significant 64 bits of the flattened 320-bit state.
    typedef type_word type_state [0:4];

    localparam int unsigned NUM_ROUNDS = 12;

    // Rounds 0..11 give {F-r, r}; 12..15 give zero so the state passes through.
    function automatic logic [7:0] round_constant(input logic [3:0] round);
        logic [7:0] c;
        c = 8'h00;
        if (round < 4'(NUM_ROUNDS)) begin
            c = {4'hF - round, round};
        end
        return c;
    endfunction

endpackage

// File: rtl/round_constant_rom.sv
// Maps a 4-bit round index to the 8-bit ASCON round constant.
// Purely combinational, zero latency; no flow control.
module round_constant_rom
    import ascon_pack::*;
(
    input  logic [3:0] round_i,
    output logic [7:0] const_o
);

    always_comb begin
        const_o = round_constant(round_i);
    end

endmodule

// File: rtl/ascon_constant_adder.sv
// ASCON p_C layer: XORs the round constant into x2[7:0] and registers the state.
// One-cycle latency; enable_i low holds the register and drops valid_o, no backpressure.
module ascon_constant_adder
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       enable_i,
    input  logic [3:0] round_i,
    input  type_state  constadd_addend_i,
    output type_state  constadd_sum_o,
    output logic       valid_o
);

    logic [7:0] round_const;
    type_state  sum_d;

    round_constant_rom u_round_constant_rom (
        .round_i (round_i),
        .const_o (round_const)
    );

    // Only the low byte of x2 sees any logic; everything else is a straight wire.
    always_comb begin
        sum_d         = constadd_addend_i;
        sum_d[2][7:0] = constadd_addend_i[2][7:0] ^ round_const;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            constadd_sum_o <= '{default: '0};
            valid_o        <= 1'b0;
        end else begin
            valid_o <= enable_i;
            if (enable_i) begin
                constadd_sum_o <= sum_d;
            end
        end
    end

endmodule

// File: tb/tb_ascon_constant_adder.sv
// Directed bench for ascon_constant_adder with a scoreboard of expected outputs.
module tb_ascon_constant_adder;
    import ascon_pack::*;

    typedef struct packed {
        logic [319:0] st;
        logic         v;
    } exp_t;

    logic       clk;
    logic       resetb;
    logic       enable;
    logic [3:0] round;
    type_state  addend;
    type_state  sum;
    logic       valid;

    int total = 0;
    int bad   = 0;

    exp_t         sb_q[$];
    logic [319:0] model_st;

    // Independent reference table of round constants.
    logic [7:0] rc_tab [0:15] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
                                  8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00};

    ascon_constant_adder dut (
        .clock_i           (clk),
        .resetb_i          (resetb),
        .enable_i          (enable),
        .round_i           (round),
        .constadd_addend_i (addend),
        .constadd_sum_o    (sum),
        .valid_o           (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [319:0] exp_st, input logic exp_v);
        for (int w = 0; w < 5; w++) begin
            chk($sformatf("%s.x%0d", tag, w), sum[w], exp_st[319-64*w -: 64]);
        end
        chk($sformatf("%s.valid", tag), {63'd0, valid}, {63'd0, exp_v});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk_state(tag, e.st, e.v);
        end
    endtask

    // Drive one cycle of stimulus, predict the register, check it after the edge.
    task automatic step(input string tag, input logic [319:0] st, input logic [3:0] r,
                        input logic en);
        exp_t e;
        @(negedge clk);
        enable = en;
        round  = r;
        for (int w = 0; w < 5; w++) addend[w] = st[319-64*w -: 64];
        if (en) begin
            model_st            = st;
            model_st[135:128]   = st[135:128] ^ rc_tab[r];
        end
        e.st = model_st;
        e.v  = en;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        logic [319:0] ones;
        logic [319:0] arb;
        logic [319:0] s;

        ones     = {320{1'b1}};
        arb      = {64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 64'h0123456789ABCDEF,
                    64'h8877665544332211, 64'hA5A5A5A55A5A5A5A};
        model_st = '0;
        resetb   = 1'b1;
        enable   = 1'b0;
        round    = 4'd0;
        addend   = '{default: '0};

        #1 resetb = 1'b0;
        #1 chk_state("reset", '0, 1'b0);
        #1 resetb = 1'b1;

        step("r0_zero", '0, 4'd0, 1'b1);
        for (int r = 1; r < 12; r++) begin
            step($sformatf("step_r%0d", r), '0, 4'(r), 1'b1);
        end

        step("ones_r5", ones, 4'd5, 1'b1);
        step("arb_r12", arb, 4'd12, 1'b1);
        step("arb_r15", arb, 4'd15, 1'b1);

        step("cap_r3", arb, 4'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom};
            step($sformatf("hold%0d", i), s, 4'($urandom_range(0, 11)), 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom};
            step($sformatf("rand%0d", i), s, 4'($urandom_range(0, 15)), 1'b1);
        end

        // Asynchronous reset in the middle of a high phase, with valid and state set.
        step("pre_reset", ones, 4'd7, 1'b1);
        #2 resetb = 1'b0;
        #1;
        model_st = '0;
        chk_state("async_reset", '0, 1'b0);
        @(posedge clk);
        #1 chk_state("reset_hold", '0, 1'b0);
        resetb = 1'b1;
        step("post_reset", arb, 4'd9, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
